// File: rtl/qracc_pkg.sv
// Shared types and helpers for the QR accumulator scheduler slice.
package qracc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } qracc_sched_state_t;

  localparam int unsigned PERF_BITS = 32;

  function automatic logic [PERF_BITS-1:0] sat_inc(input logic [PERF_BITS-1:0] v);
    return (&v) ? v : v + PERF_BITS'(1);
  endfunction

endpackage

// File: rtl/qracc_res_fifo.sv
// Synchronous result FIFO: push, pop, full/empty flags and occupancy count.
module qracc_res_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // A push on a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_en) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/qracc_scheduler.sv
// Credit-based job scheduler between input vectors, the MAC datapath and the result stream.
// Optional perf counters are built when QRACC_SCHED_PERF_EN is defined.
module qracc_scheduler
  import qracc_pkg::*;
#(
  parameter int unsigned NUM_COLS   = 32,
  parameter int unsigned ACC_BITS   = 7,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         start_i,
  input  logic [CNT_BITS-1:0]          num_vec_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic                         mac_valid_o,
  input  logic                         mac_ready_i,
  input  logic                         res_valid_i,
  input  logic [NUM_COLS*ACC_BITS-1:0] res_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NUM_COLS*ACC_BITS-1:0] out_data_o,
  output logic                         out_last_o
`ifdef QRACC_SCHED_PERF_EN
  ,
  output logic [PERF_BITS-1:0]         perf_cycles_o,
  output logic [PERF_BITS-1:0]         perf_stall_o
`endif
);

  localparam int unsigned DW  = NUM_COLS * ACC_BITS;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned UW  = ((CNT_BITS > FCW) ? CNT_BITS : FCW) + 1;

  qracc_sched_state_t  state;
  logic [CNT_BITS-1:0] num_vec;
  logic [CNT_BITS-1:0] issued;
  logic [CNT_BITS-1:0] returned;
  logic [CNT_BITS-1:0] popped;
  logic                overflow;

  logic [FCW-1:0]      fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DW-1:0]       fifo_head;

  logic                active;
  logic [CNT_BITS-1:0] inflight;
  logic [UW-1:0]       used;
  logic                has_credit;
  logic                issue;
  logic                push_req;
  logic                push_ok;
  logic                pop;
  logic                head_valid;
  logic                head_last;
  logic                start_acc;

  assign active   = (state == RUN) || (state == DRAIN);
  assign inflight = issued - returned;

  // Slots committed = buffered results plus results still inside the datapath.
  assign used       = UW'(fifo_count) + UW'(inflight);
  assign has_credit = (used < UW'(FIFO_DEPTH));

  assign issue = nrst & (state == RUN) & in_valid_i & mac_ready_i & has_credit
               & (issued < num_vec);

  assign head_valid = ~fifo_empty;
  assign pop        = head_valid & out_ready_i;
  assign push_req   = res_valid_i & active;
  assign push_ok    = push_req & (~fifo_full | pop);
  assign head_last  = active & (popped == num_vec - CNT_BITS'(1));
  assign start_acc  = (state == IDLE) & start_i;

  qracc_res_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push_req),
    .push_data (res_data_i),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      num_vec  <= '0;
      issued   <= '0;
      returned <= '0;
      popped   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      if (push_ok) begin
        returned <= returned + CNT_BITS'(1);
      end
      if (pop) begin
        popped <= popped + CNT_BITS'(1);
      end
      if (issue) begin
        issued <= issued + CNT_BITS'(1);
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            num_vec  <= num_vec_i;
            issued   <= '0;
            returned <= '0;
            popped   <= '0;
            state    <= (num_vec_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue && (issued == num_vec - CNT_BITS'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (popped == num_vec - CNT_BITS'(1))) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while nrst is asserted, even before the first reset edge.
  assign mac_valid_o = issue;
  assign in_ready_o  = issue;
  assign busy_o      = nrst & active;
  assign done_o      = nrst & (state == DONE);
  assign overflow_o  = nrst & overflow;
  assign out_valid_o = nrst & head_valid;
  assign out_last_o  = nrst & head_valid & head_last;
  assign out_data_o  = (nrst && head_valid) ? fifo_head : '0;

`ifdef QRACC_SCHED_PERF_EN
  logic [PERF_BITS-1:0] perf_cycles;
  logic [PERF_BITS-1:0] perf_stall;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start_acc) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (active) begin
        perf_cycles <= sat_inc(perf_cycles);
      end
      if ((state == RUN) && in_valid_i && !issue) begin
        perf_stall <= sat_inc(perf_stall);
      end
    end
  end

  assign perf_cycles_o = nrst ? perf_cycles : '0;
  assign perf_stall_o  = nrst ? perf_stall  : '0;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: doc/qracc_scheduler.md
QRACC_SCHEDULER -- requirements
Module: qracc_scheduler

Interface
REQ-001 SHALL have parameter NUM_COLS, default 32, the number of result lanes per vector.
REQ-002 SHALL have parameter ACC_BITS, default 7, the accumulator width per lane.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, ≥2), the result buffer depth.
REQ-004 SHALL have parameter CNT_BITS, default 16, the vector-count width.
REQ-005 SHALL have port clk, input, 1, the clock.
REQ-006 SHALL have port nrst, input, 1, the synchronous active-low reset.
REQ-007 SHALL have ports start_i (input, 1) and num_vec_i (input, CNT_BITS): job start pulse and job vector count.
REQ-008 SHALL have ports busy_o (output, 1), done_o (output, 1 pulse) and overflow_o (output, 1 sticky error).
REQ-009 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): the upstream input-vector handshake; the vector data bypasses this block.
REQ-010 SHALL have ports mac_valid_o (output, 1), mac_ready_i (input, 1), res_valid_i (input, 1) and res_data_i (input, NUM_COLS*ACC_BITS): the MAC-datapath side.
REQ-011 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, NUM_COLS*ACC_BITS) and out_last_o (output, 1): the downstream result stream.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-013 In IDLE, start_i SHALL latch num_vec_i and clear issued/returned counters; next state is RUN, or DONE when num_vec_i==0.
REQ-014 start_i outside IDLE SHALL be ignored, with no state change.
REQ-015 In RUN, issue = in_valid_i & mac_ready_i & (credits>0) & (issued<num_vec), combinationally.
REQ-016 mac_valid_o and in_ready_o SHALL both equal issue; no registered stage, zero added latency.
REQ-017 credits SHALL equal FIFO_DEPTH − fifo_count − inflight, where inflight = issued − returned.
REQ-018 An issue consumes one credit and a FIFO pop returns one; a simultaneous issue and pop SHALL leave credits unchanged.
REQ-019 RUN→DRAIN SHALL occur on the cycle issued reaches num_vec.
REQ-020 res_valid_i SHALL push res_data_i into the FIFO and increment returned; the block SHALL NOT assume any fixed datapath latency.
REQ-021 res_valid_i with the FIFO full SHALL drop the data and set overflow_o; overflow_o clears only on reset.
REQ-022 A push and a pop in the same cycle on a full FIFO SHALL both succeed, with count unchanged.
REQ-023 out_valid_o = FIFO non-empty; out_data_o = FIFO head, held stable while out_valid_o & !out_ready_i.
REQ-024 out_last_o SHALL be high with the head entry that is the num_vec-th result of the job.
REQ-025 DRAIN→DONE SHALL occur on the cycle the last result is popped.
REQ-026 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE.
REQ-027 busy_o SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-028 Counters SHALL be CNT_BITS wide; num_vec = 2^CNT_BITS−1 SHALL complete without wrap.

Reset
REQ-029 On nrst=0 at a clk edge: state=IDLE, all counters 0, FIFO empty, overflow_o=0.
REQ-030 Under reset, all outputs SHALL be 0 (busy_o, done_o, mac_valid_o, in_ready_o, out_valid_o, out_last_o, out_data_o).
REQ-031 Reset mid-job SHALL abandon the job; results arriving after reset are pushed only if a new job is in RUN/DRAIN, otherwise ignored.

Configuration
REQ-032 With QRACC_SCHED_PERF_EN defined, the block SHALL add outputs perf_cycles_o and perf_stall_o (32 bits each).
REQ-033 perf_cycles_o SHALL count busy cycles; perf_stall_o SHALL count RUN cycles with in_valid_i=1 and issue=0.
REQ-034 Both perf counters SHALL clear on start acceptance and saturate at all-ones.
REQ-035 Without QRACC_SCHED_PERF_EN, these ports and counters SHALL be absent.

Structure
REQ-036 The FSM state enum qracc_sched_state_t SHALL live in qracc_pkg.
REQ-037 The result buffer SHALL be a sub-module qracc_res_fifo (synchronous FIFO with push, pop, full, empty and count).

Verification
REQ-038 Zero-length job: num_vec=0, start → done_o pulses exactly once, 1 cycle after start, with no mac_valid_o activity.
REQ-039 Basic job: num_vec=3, mac_ready_i=1, datapath results at 6-cycle latency, out_ready_i=1 → 3 outputs in order, out_last_o on the 3rd, then done_o.
REQ-040 Backpressure: FIFO_DEPTH=4, num_vec=10, out_ready_i=0 → exactly 4 issues, then in_ready_o=0.
REQ-041 Backpressure release: in the REQ-040 scenario, raise out_ready_i → remaining 6 issue and all 10 results delivered.
REQ-042 Injected fault: an extra res_valid_i while the FIFO is full → overflow_o=1, FIFO contents unchanged.
REQ-043 Reset and restart: nrst pulsed in RUN after 2 of 5 issues → all outputs 0; a new num_vec=2 job then completes normally.
